// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch constants, FSM state encoding and PC arithmetic helper.
package fetch_ctrl_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_REFILL = 2'b00,
        FETCH_RUN    = 2'b01,
        FETCH_HALT   = 2'b10
    } fetch_state_e;

    // Sequential successor; the add wraps modulo 2^32 by width.
    function automatic logic [PC_W-1:0] pc_add4(input logic [PC_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction RAM read port plus the IF-stage output bundle of fetch_ctrl.
interface fetch_ctrl_if #(
    parameter int unsigned AW = 10
);
    import fetch_ctrl_pkg::*;

    logic [AW-1:0]     instr_ram_addr;
    logic              instr_ram_rd;
    logic [DATA_W-1:0] instr_ram_din;
    logic [PC_W-1:0]   if_pc;
    logic [DATA_W-1:0] if_instruction;
    logic              if_valid;

    modport master (
        output instr_ram_addr,
        output instr_ram_rd,
        input  instr_ram_din,
        output if_pc,
        output if_instruction,
        output if_valid
    );

    modport slave (
        input  instr_ram_addr,
        input  instr_ram_rd,
        output instr_ram_din,
        input  if_pc,
        input  if_instruction,
        input  if_valid
    );

endinterface

// File: rtl/fetch_npc_sel.sv
// Next-PC selection: redirect priority mux, +4 adder and redirect alignment check.
// FETCH_MISALIGN_CHK_EN enables flagging of misaligned redirect targets.
module fetch_npc_sel
    import fetch_ctrl_pkg::*;
(
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            trap_redirect,
    input  logic [PC_W-1:0] trap_target,
    input  logic            branch_redirect,
    input  logic [PC_W-1:0] branch_target,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            misalign,
    output logic [PC_W-1:0] misalign_addr,
    output logic [PC_W-1:0] seq_pc
);

    logic [PC_W-1:0] sel_pc_s;

    // Trap outranks branch when both request a redirect.
    always_comb begin
        sel_pc_s = branch_target;
        if (trap_redirect) begin
            sel_pc_s = trap_target;
        end else begin
            sel_pc_s = branch_target;
        end
    end

    assign redirect    = trap_redirect | branch_redirect;
    assign redirect_pc = sel_pc_s & {{(PC_W-2){1'b1}}, 2'b00};
    assign seq_pc      = pc_add4(fetch_pc);

`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign      = redirect & (sel_pc_s[1:0] != 2'b00);
    assign misalign_addr = misalign ? sel_pc_s : {PC_W{1'b0}};
`else
    assign misalign      = 1'b0;
    assign misalign_addr = {PC_W{1'b0}};
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: REFILL/RUN/HALT FSM driving a 1-cycle-latency RAM.
// FETCH_MISALIGN_CHK_EN enables misaligned redirect detection (halt + misalign_exc).
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned INSTR_RAM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              halt,
    input  logic              trap_redirect,
    input  logic [31:0]       trap_target,
    input  logic              branch_redirect,
    input  logic [31:0]       branch_target,
    fetch_ctrl_if.master      bus,
    output logic              misalign_exc,
    output logic [31:0]       misalign_addr
);

    fetch_state_e    state_r, state_nxt_s;
    logic [PC_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [PC_W-1:0] if_pc_r, if_pc_nxt_s;
    logic            if_valid_r, if_valid_nxt_s;
    logic            misalign_exc_r, misalign_exc_nxt_s;
    logic [PC_W-1:0] misalign_addr_r, misalign_addr_nxt_s;
    logic            rd_s;

    logic            redirect_s;
    logic [PC_W-1:0] redirect_pc_s;
    logic            misalign_s;
    logic [PC_W-1:0] bad_addr_s;
    logic [PC_W-1:0] seq_pc_s;

    fetch_npc_sel u_npc_sel (
        .fetch_pc        (fetch_pc_r),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target),
        .branch_redirect (branch_redirect),
        .branch_target   (branch_target),
        .redirect        (redirect_s),
        .redirect_pc     (redirect_pc_s),
        .misalign        (misalign_s),
        .misalign_addr   (bad_addr_s),
        .seq_pc          (seq_pc_s)
    );

    // Next-state and read-enable decode; a redirect overrides stall and halt.
    always_comb begin
        state_nxt_s         = state_r;
        fetch_pc_nxt_s      = fetch_pc_r;
        if_pc_nxt_s         = if_pc_r;
        if_valid_nxt_s      = if_valid_r;
        misalign_exc_nxt_s  = 1'b0;
        misalign_addr_nxt_s = misalign_addr_r;
        rd_s                = 1'b0;
        if (redirect_s) begin
            if_valid_nxt_s = 1'b0;
            if (misalign_s) begin
                state_nxt_s         = FETCH_HALT;
                misalign_exc_nxt_s  = 1'b1;
                misalign_addr_nxt_s = bad_addr_s;
            end else begin
                state_nxt_s    = FETCH_REFILL;
                fetch_pc_nxt_s = redirect_pc_s;
            end
        end else begin
            case (state_r)
                FETCH_REFILL: begin
                    rd_s           = 1'b1;
                    if_pc_nxt_s    = fetch_pc_r;
                    fetch_pc_nxt_s = seq_pc_s;
                    if_valid_nxt_s = 1'b1;
                    state_nxt_s    = FETCH_RUN;
                end
                FETCH_RUN: begin
                    if (stall) begin
                        rd_s = 1'b0;
                    end else if (halt) begin
                        if_valid_nxt_s = 1'b0;
                        state_nxt_s    = FETCH_HALT;
                    end else begin
                        rd_s           = 1'b1;
                        if_pc_nxt_s    = fetch_pc_r;
                        fetch_pc_nxt_s = seq_pc_s;
                        if_valid_nxt_s = 1'b1;
                    end
                end
                FETCH_HALT: begin
                    if_valid_nxt_s = 1'b0;
                end
                default: begin
                    if_valid_nxt_s = 1'b0;
                    state_nxt_s    = FETCH_REFILL;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= FETCH_REFILL;
            fetch_pc_r      <= RESET_PC;
            if_pc_r         <= {PC_W{1'b0}};
            if_valid_r      <= 1'b0;
            misalign_exc_r  <= 1'b0;
            misalign_addr_r <= {PC_W{1'b0}};
        end else begin
            state_r         <= state_nxt_s;
            fetch_pc_r      <= fetch_pc_nxt_s;
            if_pc_r         <= if_pc_nxt_s;
            if_valid_r      <= if_valid_nxt_s;
            misalign_exc_r  <= misalign_exc_nxt_s;
            misalign_addr_r <= misalign_addr_nxt_s;
        end
    end

    assign bus.instr_ram_addr = fetch_pc_r[INSTR_RAM_AW+1:2];
    assign bus.instr_ram_rd   = rd_s & ~rst;
    assign bus.if_pc          = if_pc_r;
    assign bus.if_instruction = bus.instr_ram_din;
    assign bus.if_valid       = if_valid_r;
    assign misalign_exc       = misalign_exc_r;
    assign misalign_addr      = misalign_addr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, corner sequences, random vs. model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, halt, trap_redirect, branch_redirect;
    logic [31:0] trap_target, branch_target;
    logic        misalign_exc;
    logic [31:0] misalign_addr;
    int          checks = 0;
    int          errors = 0;

    fetch_ctrl_if #(.AW(10)) bus ();

    fetch_ctrl #(.RESET_PC(RESET_PC), .INSTR_RAM_AW(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .halt            (halt),
        .trap_redirect   (trap_redirect),
        .trap_target     (trap_target),
        .branch_redirect (branch_redirect),
        .branch_target   (branch_target),
        .bus             (bus),
        .misalign_exc    (misalign_exc),
        .misalign_addr   (misalign_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return {22'h0, a} * 32'h9E37_79B9 + 32'h1357_2468;
    endfunction

    // Instruction RAM: one-cycle read latency, output held when not reading.
    always @(posedge clk) begin
        if (bus.instr_ram_rd) bus.instr_ram_din <= mem_word(bus.instr_ram_addr);
    end

    typedef struct {
        logic        s, h, b;
        logic [31:0] bt;
        logic        t;
        logic [31:0] tt;
        logic        chk_rd, exp_rd;
        logic [9:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vec [27];

    function automatic vec_t mk(input logic s, input logic h, input logic b, input logic [31:0] bt,
                                input logic t, input logic [31:0] tt, input logic cr, input logic er,
                                input logic [9:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.s = s; v.h = h; v.b = b; v.bt = bt; v.t = t; v.tt = tt;
        v.chk_rd = cr; v.exp_rd = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic h, input logic b, input logic [31:0] bt,
                          input logic t, input logic [31:0] tt);
        rst = 1'b0; stall = s; halt = h;
        branch_redirect = b; branch_target = bt;
        trap_redirect = t; trap_target = tt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string nm, input logic ev, input logic [31:0] ep);
        chk({nm, "_valid"}, 32'(bus.if_valid), 32'(ev));
        if (ev) begin
            chk({nm, "_pc"}, bus.if_pc, ep);
            chk({nm, "_instr"}, bus.if_instruction, mem_word(ep[11:2]));
        end
    endtask

    // Behavioural reference state for the random phase.
    logic [31:0] m_npc, m_pc, m_maddr, m_tgt;
    logic        m_valid, m_exc, m_known, m_bad;
    int          m_mode;
    localparam int M_FILL = 0, M_STREAM = 1, M_STOPPED = 2;

    function automatic logic [31:0] rnd_target();
        logic [31:0] t;
        if ($urandom_range(0, 5) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 12));
        else t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 5) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    initial begin
        // reset state
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        step();
        #2;
        chk("rst_rd", 32'(bus.instr_ram_rd), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_mexc", 32'(misalign_exc), 32'd0);
        chk("rst_maddr", misalign_addr, 32'h0);
        step();

        vec[0]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h000,0,32'h0);
        vec[1]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h001,1,32'h0);
        vec[2]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h002,1,32'h4);
        vec[3]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h003,1,32'h8);
        vec[4]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h004,1,32'hC);
        vec[5]  = mk(1,0,0,32'h0,  0,32'h0,  1,0,10'h005,1,32'h10);
        vec[6]  = mk(1,0,0,32'h0,  0,32'h0,  1,0,10'h005,1,32'h10);
        vec[7]  = mk(1,0,0,32'h0,  0,32'h0,  1,0,10'h005,1,32'h10);
        vec[8]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h005,1,32'h10);
        vec[9]  = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h006,1,32'h14);
        vec[10] = mk(0,0,1,32'h100,1,32'h200,0,0,10'h007,1,32'h18);
        vec[11] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h080,0,32'h0);
        vec[12] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h081,1,32'h200);
        vec[13] = mk(1,0,1,32'h40, 0,32'h0,  0,0,10'h082,1,32'h204);
        vec[14] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h010,0,32'h0);
        vec[15] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h011,1,32'h40);
        vec[16] = mk(0,0,1,32'h18, 0,32'h0,  0,0,10'h012,1,32'h44);
        vec[17] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h006,0,32'h0);
        vec[18] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h007,1,32'h18);
        vec[19] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h008,1,32'h1C);
        vec[20] = mk(0,1,0,32'h0,  0,32'h0,  1,0,10'h009,1,32'h20);
        vec[21] = mk(0,0,0,32'h0,  0,32'h0,  1,0,10'h009,0,32'h0);
        vec[22] = mk(0,0,0,32'h0,  0,32'h0,  1,0,10'h009,0,32'h0);
        vec[23] = mk(0,0,0,32'h0,  0,32'h0,  1,0,10'h009,0,32'h0);
        vec[24] = mk(0,0,1,32'h80, 0,32'h0,  0,0,10'h009,0,32'h0);
        vec[25] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h020,0,32'h0);
        vec[26] = mk(0,0,0,32'h0,  0,32'h0,  1,1,10'h021,1,32'h80);

        for (int i = 0; i < 27; i++) begin
            set_in(vec[i].s, vec[i].h, vec[i].b, vec[i].bt, vec[i].t, vec[i].tt);
            #2;
            if (vec[i].chk_rd) chk($sformatf("vec%0d_rd", i), 32'(bus.instr_ram_rd), 32'(vec[i].exp_rd));
            chk($sformatf("vec%0d_addr", i), 32'(bus.instr_ram_addr), 32'(vec[i].exp_addr));
            chk_fetch($sformatf("vec%0d", i), vec[i].exp_valid, vec[i].exp_pc);
            step();
        end

        // misaligned branch target
        set_in(1'b0, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
        #2;
        chk_fetch("mis_pre", 1'b1, 32'h84);
        step();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_exc_pulse", 32'(misalign_exc), 32'd1);
        chk("mis_addr", misalign_addr, 32'h102);
        chk("mis_rd", 32'(bus.instr_ram_rd), 32'd0);
        chk_fetch("mis_halt", 1'b0, 32'h0);
        step();
        #2;
        chk("mis_exc_end", 32'(misalign_exc), 32'd0);
        chk("mis_addr_hold", misalign_addr, 32'h102);
        chk("mis_halt_rd", 32'(bus.instr_ram_rd), 32'd0);
        step();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        step();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("mis_refill_rd", 32'(bus.instr_ram_rd), 32'd1);
        chk("mis_refill_addr", 32'(bus.instr_ram_addr), 32'h0C0);
        chk_fetch("mis_refill", 1'b0, 32'h0);
        step();
        #2;
        chk_fetch("mis_recover", 1'b1, 32'h300);
        chk("mis_exc_quiet", 32'(misalign_exc), 32'd0);
`else
        chk("mis_exc_tied", 32'(misalign_exc), 32'd0);
        chk("mis_addr_tied", misalign_addr, 32'h0);
        chk("mis_refill_rd", 32'(bus.instr_ram_rd), 32'd1);
        chk("mis_refill_addr", 32'(bus.instr_ram_addr), 32'h040);
        chk_fetch("mis_refill", 1'b0, 32'h0);
        step();
        #2;
        chk_fetch("mis_forced", 1'b1, 32'h100);
`endif
        step();

        // 32-bit wrap of the fetch PC
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        step();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wpc;
            wpc = 32'hFFFF_FFF8 + 32'(k * 4);
            #2;
            chk_fetch($sformatf("wrap%0d", k), 1'b1, wpc);
            step();
        end

        // reset in the middle of streaming
        rst = 1'b1;
        #2;
        chk("midrst_rd", 32'(bus.instr_ram_rd), 32'd0);
        step();
        rst = 1'b0;
        #2;
        chk("midrst_rd1", 32'(bus.instr_ram_rd), 32'd1);
        chk("midrst_addr", 32'(bus.instr_ram_addr), 32'(RESET_PC[11:2]));
        chk_fetch("midrst_fill", 1'b0, 32'h0);
        step();
        #2;
        chk_fetch("midrst_first", 1'b1, RESET_PC);
        step();

        // randomized run against the reference model
        m_known = 1'b0;
        m_npc = 32'h0; m_pc = 32'h0; m_maddr = 32'h0;
        m_valid = 1'b0; m_exc = 1'b0; m_mode = M_FILL;
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                   $urandom_range(0, 24) == 0, rnd_target(),
                   $urandom_range(0, 49) == 0, rnd_target());
            rst = (n == 0) || ($urandom_range(0, 299) == 0);
            #2;
            if (rst) begin
                chk("rnd_rd_rst", 32'(bus.instr_ram_rd), 32'd0);
            end else if (m_known) begin
                chk_fetch("rnd", m_valid, m_pc);
                chk("rnd_addr", 32'(bus.instr_ram_addr), 32'(m_npc[11:2]));
                if (!(trap_redirect || branch_redirect))
                    chk("rnd_rd", 32'(bus.instr_ram_rd),
                        32'((m_mode == M_FILL) || (m_mode == M_STREAM && !stall && !halt)));
                chk("rnd_mexc", 32'(misalign_exc), 32'(m_exc));
                chk("rnd_maddr", misalign_addr, m_maddr);
            end
            step();
            if (rst) begin
                m_known = 1'b1; m_mode = M_FILL; m_npc = RESET_PC; m_pc = 32'h0;
                m_valid = 1'b0; m_exc = 1'b0; m_maddr = 32'h0;
            end else if (trap_redirect || branch_redirect) begin
                m_tgt = trap_redirect ? trap_target : branch_target;
`ifdef FETCH_MISALIGN_CHK_EN
                m_bad = (m_tgt % 4) != 0;
`else
                m_bad = 1'b0;
`endif
                m_valid = 1'b0;
                m_exc = m_bad;
                if (m_bad) begin
                    m_maddr = m_tgt;
                    m_mode = M_STOPPED;
                end else begin
                    m_npc = m_tgt - (m_tgt % 4);
                    m_mode = M_FILL;
                end
            end else begin
                m_exc = 1'b0;
                if (m_mode == M_FILL || (m_mode == M_STREAM && !stall && !halt)) begin
                    m_pc = m_npc;
                    m_npc = m_npc + 32'd4;
                    m_valid = 1'b1;
                    m_mode = M_STREAM;
                end else if (m_mode == M_STREAM && !stall && halt) begin
                    m_valid = 1'b0;
                    m_mode = M_STOPPED;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
